jk_bank_sequencer: RTL and testbench

//  - Command-driven controller for a bank of W JK flip-flops sharing one clock.
//  - Translates high-level ops (set/clear/toggle mask, load value, count up/down N steps)

---
 rtl/jk_bank_sequencer_if.sv | 13 +
 rtl/jk_bank_sequencer.sv | 168 ++++++++++++++++
 tb/tb_jk_bank_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/jk_bank_sequencer_if.sv
// Command channel between a command source and jk_bank_sequencer.
// The source drives op/arg under valid; the sequencer answers with ready.
interface jk_bank_sequencer_if #(
    parameter int W = 4
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_arg;

    modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/jk_bank_sequencer.sv
// Command-driven controller producing registered J/K drive for a bank of W JK flip-flops.
// Optional Q-vs-shadow checker enabled by defining JKSEQ_VERIFY_EN.
module jk_bank_sequencer #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    jk_bank_sequencer_if.slave   cmd,
    input  logic [W-1:0]         Q,
    output logic [W-1:0]         J,
    output logic [W-1:0]         K,
    output logic                 busy,
    output logic                 done,
    output logic [W-1:0]         shadow,
    output logic                 err
);

    typedef enum logic [2:0] {
        OP_NOP    = 3'b000,
        OP_SET    = 3'b001,
        OP_CLR    = 3'b010,
        OP_TOG    = 3'b011,
        OP_LOAD   = 3'b100,
        OP_CNT_UP = 3'b101,
        OP_CNT_DN = 3'b110,
        OP_SYNC   = 3'b111
    } op_e;

    typedef enum logic [1:0] {S_IDLE, S_APPLY, S_COUNT} state_e;

    state_e             state, state_nx;
    op_e                op;
    logic               accept;
    logic [CNT_W-1:0]   n_steps, cnt_q, cnt_nx;
    logic               dir_up_q, dir_up_nx;
    logic [W-1:0]       j_nx, k_nx, shadow_nx;
    logic               done_nx;
    logic               last_step;

    assign cmd.cmd_ready = (state == S_IDLE);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign op            = op_e'(cmd.cmd_op);
    assign n_steps       = CNT_W'(cmd.cmd_arg);
    assign last_step     = (cnt_q == CNT_W'(1));

    // Bit i toggles when all lower bits are 1 (up) or all 0 (down).
    function automatic logic [W-1:0] toggle_mask(input logic [W-1:0] s, input logic up);
        logic run;
        toggle_mask = '0;
        run = 1'b1;
        for (int i = 0; i < W; i++) begin
            toggle_mask[i] = run;
            run = run & (up ? s[i] : ~s[i]);
        end
    endfunction

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        // NOTE: every combinational output is defaulted first so no latch is inferred.
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_SET, OP_CLR, OP_TOG, OP_LOAD: state_nx = S_APPLY;
                        OP_CNT_UP, OP_CNT_DN:            if (n_steps != '0) state_nx = S_COUNT;
                        default:                         state_nx = S_IDLE;
                    endcase
                end
            end
            S_APPLY: state_nx = S_IDLE;
            S_COUNT: if (last_step) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        j_nx      = '0;
        k_nx      = '0;
        done_nx   = 1'b0;
        shadow_nx = shadow;
        cnt_nx    = cnt_q;
        dir_up_nx = dir_up_q;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_SET:  j_nx = cmd.cmd_arg;
                        OP_CLR:  k_nx = cmd.cmd_arg;
                        OP_TOG:  begin j_nx = cmd.cmd_arg; k_nx = cmd.cmd_arg;  end
                        OP_LOAD: begin j_nx = cmd.cmd_arg; k_nx = ~cmd.cmd_arg; end
                        OP_CNT_UP, OP_CNT_DN: begin
                            dir_up_nx = (op == OP_CNT_UP);
                            cnt_nx    = n_steps;
                            if (n_steps == '0) begin
                                done_nx = 1'b1;
                            end else begin
                                j_nx = toggle_mask(shadow, dir_up_nx);
                                k_nx = j_nx;
                            end
                        end
                        OP_SYNC: begin shadow_nx = Q; done_nx = 1'b1; end
                        default: done_nx = 1'b1;
                    endcase
                end
            end
            // Predict the bank with the JK characteristic equation on the drive just applied.
            S_APPLY: begin
                shadow_nx = (J & ~shadow) | (~K & shadow);
                done_nx   = 1'b1;
            end
            S_COUNT: begin
                shadow_nx = dir_up_q ? shadow + W'(1) : shadow - W'(1);
                cnt_nx    = cnt_q - CNT_W'(1);
                if (last_step) begin
                    done_nx = 1'b1;
                end else begin
                    j_nx = toggle_mask(shadow_nx, dir_up_q);
                    k_nx = j_nx;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        // NOTE: registered state uses non-blocking assignments only.
        if (RESET) begin
            J        <= '0;
            K        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            shadow   <= '0;
            cnt_q    <= '0;
            dir_up_q <= 1'b0;
        end else begin
            J        <= j_nx;
            K        <= k_nx;
            busy     <= (state_nx != S_IDLE);
            done     <= done_nx;
            shadow   <= shadow_nx;
            cnt_q    <= cnt_nx;
            dir_up_q <= dir_up_nx;
        end
    end

`ifdef JKSEQ_VERIFY_EN
    logic chk_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            chk_q <= 1'b0;
            err   <= 1'b0;
        end else begin
            chk_q <= (state != S_IDLE) || (accept && op == OP_SYNC);
            if (chk_q && (Q != shadow)) err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Self-checking bench: jk_bank_sequencer driving a 4-bit JK bank, compared to an arithmetic model.
// Inputs change on negedge, outputs are sampled on negedge.
module tb_jk_bank_sequencer;

    localparam int W     = 4;
    localparam int CNT_W = 8;

    localparam logic [2:0] NOP = 3'd0, SET = 3'd1, CLR = 3'd2, TOG = 3'd3;
    localparam logic [2:0] LOAD = 3'd4, CNT_UP = 3'd5, CNT_DN = 3'd6, SYNC = 3'd7;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [W-1:0]  Q, J, K, shadow;
    logic          busy, done, err;

    always #5 CLK = ~CLK;

    jk_bank_sequencer_if #(.W(W)) cmd_if ();

    jk_bank_sequencer #(.W(W), .CNT_W(CNT_W)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .cmd    (cmd_if),
        .Q      (Q),
        .J      (J),
        .K      (K),
        .busy   (busy),
        .done   (done),
        .shadow (shadow),
        .err    (err)
    );

    // JK bank with an arbitrary power-up value; flip models an upset on its outputs.
    logic [W-1:0] bank_q = 4'b1001;
    logic [W-1:0] flip;
    always @(posedge CLK) bank_q <= (J & ~bank_q) | (~K & bank_q);
    assign Q = bank_q ^ flip;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] m_bank  = 4'b1001;
    logic [W-1:0] m_sh    = '0;
    logic         exp_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_done(input string tag);
        check({tag, "_done"},   done, 1'b1);
        check({tag, "_busy"},   busy, 1'b0);
        check({tag, "_j"},      J, '0);
        check({tag, "_k"},      K, '0);
        check({tag, "_ready"},  cmd_if.cmd_ready, 1'b1);
        check({tag, "_shadow"}, shadow, m_sh);
        check({tag, "_q"},      Q, m_bank);
        check({tag, "_err"},    err, exp_err);
    endtask

    task automatic noise();
        cmd_if.cmd_valid = 1'($urandom_range(0, 1));
        cmd_if.cmd_op    = 3'($urandom);
        cmd_if.cmd_arg   = W'($urandom);
    endtask

    // Called at a negedge; returns at the negedge where done is visible.
    task automatic do_cmd(input logic [2:0] op, input logic [W-1:0] arg);
        logic [W-1:0] ej, ek, nxt, t;
        int n;
        check("ready_before", cmd_if.cmd_ready, 1'b1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_arg   = arg;
        @(negedge CLK);
        case (op)
            SET, CLR, TOG, LOAD: begin
                noise();
                case (op)
                    SET:     begin ej = arg; ek = '0;   m_bank = m_bank | arg;  m_sh = m_sh | arg;  end
                    CLR:     begin ej = '0;  ek = arg;  m_bank = m_bank & ~arg; m_sh = m_sh & ~arg; end
                    TOG:     begin ej = arg; ek = arg;  m_bank = m_bank ^ arg;  m_sh = m_sh ^ arg;  end
                    default: begin ej = arg; ek = ~arg; m_bank = arg;           m_sh = arg;         end
                endcase
                check("apply_j", J, ej);
                check("apply_k", K, ek);
                check("apply_busy", busy, 1'b1);
                check("apply_done", done, 1'b0);
                check("apply_ready", cmd_if.cmd_ready, 1'b0);
                @(negedge CLK);
                cmd_if.cmd_valid = 1'b0;
                check_done("apply");
            end
            CNT_UP, CNT_DN: begin
                n = int'(arg);
                for (int s = 0; s < n; s++) begin
                    noise();
                    nxt = (op == CNT_UP) ? m_sh + 4'd1 : m_sh - 4'd1;
                    t   = m_sh ^ nxt;
                    check("count_j", J, t);
                    check("count_k", K, t);
                    check("count_busy", busy, 1'b1);
                    check("count_done", done, 1'b0);
                    check("count_ready", cmd_if.cmd_ready, 1'b0);
                    check("count_shadow", shadow, m_sh);
                    m_sh   = nxt;
                    m_bank = m_bank ^ t;
                    @(negedge CLK);
                    check("count_q", Q, m_bank);
                end
                cmd_if.cmd_valid = 1'b0;
                check_done("count");
            end
            default: begin
                cmd_if.cmd_valid = 1'b0;
                if (op == SYNC) m_sh = m_bank;
                check_done(op == SYNC ? "sync" : "nop");
            end
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET            = 1'b1;
        flip             = '0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = NOP;
        cmd_if.cmd_arg   = '0;
        @(negedge CLK);
        @(negedge CLK);
        check("rst_j", J, '0);
        check("rst_k", K, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_shadow", shadow, '0);
        check("rst_ready", cmd_if.cmd_ready, 1'b1);
        check("rst_err", err, 1'b0);
        RESET = 1'b0;
        @(negedge CLK);

        // Directed sequence, issued back-to-back from each done cycle.
        do_cmd(SYNC, '0);
        do_cmd(LOAD, 4'b1010);
        check("load_q", Q, 4'b1010);
        do_cmd(SET, 4'b0101);
        check("set_q", Q, 4'b1111);
        do_cmd(CLR, 4'b1000);
        check("clr_q", Q, 4'b0111);
        do_cmd(TOG, 4'b0011);
        check("tog_q", Q, 4'b0100);
        do_cmd(LOAD, 4'b1110);
        do_cmd(CNT_UP, 4'd3);
        check("cntup_q", Q, 4'b0001);
        do_cmd(LOAD, 4'b0001);
        do_cmd(CNT_DN, 4'd2);
        check("cntdn_q", Q, 4'b1111);
        do_cmd(CNT_UP, 4'd0);
        do_cmd(NOP, 4'b1111);

        // Reset in the middle of a count.
        do_cmd(LOAD, 4'b0000);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = CNT_UP;
        cmd_if.cmd_arg   = 4'd5;
        @(negedge CLK);
        cmd_if.cmd_valid = 1'b0;
        check("mid_j1", J, 4'b0001);
        @(negedge CLK);
        check("mid_q1", Q, 4'b0001);
        @(negedge CLK);
        check("mid_q2", Q, 4'b0010);
        RESET = 1'b1;
        #1;
        check("mid_rst_j", J, '0);
        check("mid_rst_k", K, '0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_shadow", shadow, '0);
        check("mid_rst_ready", cmd_if.cmd_ready, 1'b1);
        @(negedge CLK);
        check("mid_hold_q", Q, 4'b0010);
        RESET  = 1'b0;
        m_bank = 4'b0010;
        m_sh   = '0;
        @(negedge CLK);
        do_cmd(SYNC, '0);
        check("mid_sync_shadow", shadow, 4'b0010);

        // Random commands against the model.
        for (int i = 0; i < 40; i++) begin
            do_cmd(3'($urandom_range(0, 7)), W'($urandom));
        end

`ifdef JKSEQ_VERIFY_EN
        do_cmd(LOAD, 4'b0110);
        flip = 4'b0001;
        @(negedge CLK);
        check("verify_err_set", err, 1'b1);
        flip    = '0;
        exp_err = 1'b1;
        do_cmd(TOG, 4'b1111);
        do_cmd(CNT_UP, 4'd2);
        RESET = 1'b1;
        #1;
        check("verify_err_clr", err, 1'b0);
        exp_err = 1'b0;
        m_sh    = '0;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        do_cmd(SYNC, '0);
`else
        check("err_tied_low", err, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
